// File: rtl/operand_mux_pkg.sv
// Purpose: shared defaults and select-width helper for the operand mux stage.
// Ports:   none (package).
package operand_mux_pkg;

    localparam int unsigned OPMUX_DEF_WIDTH = 32;
    localparam int unsigned OPMUX_DEF_N_IN  = 4;
    localparam int unsigned OPMUX_MAX_N_IN  = 16;

    // Binary select width for n inputs (at least one bit)
    function automatic int unsigned opmux_sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : operand_mux_pkg

// File: rtl/operand_mux_if.sv
// Purpose: operand-select bus bundling upstream beat, flush and downstream handshake.
// Ports:   in_data/sel/in_valid/in_ready (upstream), flush, out_data/out_valid/out_ready
//          (downstream), sel_err when OPERAND_MUX_SEL_CHECK_EN is defined.
//          slave = the stage, master = its environment.
interface operand_mux_if
    import operand_mux_pkg::*;
#(
    parameter int unsigned WIDTH = OPMUX_DEF_WIDTH,
    parameter int unsigned N_IN  = OPMUX_DEF_N_IN
) ();

    localparam int unsigned SEL_W = opmux_sel_w(N_IN);

    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef OPERAND_MUX_SEL_CHECK_EN
    logic                  sel_err;
`endif

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
`ifdef OPERAND_MUX_SEL_CHECK_EN
        output sel_err,
`endif
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
`ifdef OPERAND_MUX_SEL_CHECK_EN
        input  sel_err,
`endif
        input  in_ready, out_data, out_valid
    );

endinterface : operand_mux_if

// File: rtl/skid_buffer_2.sv
// Purpose: two-entry valid/ready buffer (main + skid) with synchronous flush.
//          in_ready and out_valid are direct state-flop bits, so there is no
//          combinational path from out_ready to in_ready.
// Ports:   clk, rst_n (async active-low), flush, in_data/in_valid/in_ready,
//          out_data/out_valid/out_ready.
module skid_buffer_2
    import operand_mux_pkg::*;
#(
    parameter int unsigned WIDTH = OPMUX_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    // Encoding doubles as the valid bits: [1] = skid valid, [0] = main valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] main_data, next_main;
    logic [WIDTH-1:0] skid_data, next_skid;
    logic             accept;
    logic             pop;

    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    assign out_data  = main_data;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    // State and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state     <= next_state;
            main_data <= next_main;
            skid_data <= next_skid;
        end
    end

    // Next-state and data steering; flush wins over everything
    always_comb begin
        next_state = state;
        next_main  = main_data;
        next_skid  = skid_data;
        if (flush) begin
            next_state = EMPTY;
            next_main  = '0;
            next_skid  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state = ONE;
                        next_main  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        next_main = in_data;
                    end else if (accept) begin
                        next_state = FULL;
                        next_skid  = in_data;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        next_state = ONE;
                        next_main  = skid_data;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

endmodule : skid_buffer_2

// File: rtl/operand_mux_stage.sv
// Purpose: N_IN:1 operand select feeding a registered two-entry skid buffer.
//          Out-of-range selects yield zero data. With OPERAND_MUX_SEL_CHECK_EN
//          defined, a sticky sel_err flags accepted out-of-range selects.
// Ports:   clk, rst_n (async active-low), bus (operand_mux_if.slave).
module operand_mux_stage
    import operand_mux_pkg::*;
#(
    parameter int unsigned WIDTH = OPMUX_DEF_WIDTH,
    parameter int unsigned N_IN  = OPMUX_DEF_N_IN
) (
    input  logic          clk,
    input  logic          rst_n,
    operand_mux_if.slave  bus
);

    localparam int unsigned SEL_W = opmux_sel_w(N_IN);

    logic [WIDTH-1:0] mux_data;

    // Binary select; unmatched codes leave the zero default
    always_comb begin
        mux_data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                mux_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    skid_buffer_2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_data   (mux_data),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

`ifdef OPERAND_MUX_SEL_CHECK_EN
    logic sel_ok;
    logic accept;
    logic sel_err_q;

    assign sel_ok = (32'(bus.sel) < N_IN);
    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

    // Sticky error; only flush or reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (bus.flush) begin
            sel_err_q <= 1'b0;
        end else if (accept && !sel_ok) begin
            sel_err_q <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_q;
`endif

endmodule : operand_mux_stage

// File: doc/operand_mux_stage.md
# operand_mux_stage

Parametrised N:1 operand-select multiplexer with a registered, back-pressurable output stage for the pipelined CPU datapath. It generalises the 2:1 combinational select used between pipeline stages. It adds a configurable input count and width, a valid/ready handshake, a two-entry skid buffer for full throughput under stall, and a synchronous flush for branch/exception squash. It sits between the forwarding/operand-select logic and the execute stage.

## Interface
- WIDTH, 32, data width of each input and of the output
- N_IN, 4, number of selectable inputs (2..16)
- SEL_W, $clog2(N_IN), select width (derived, not overridden)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  binary select, sampled with in_valid
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage can accept a beat this cycle
- flush  input  1  synchronous squash of all buffered beats
- out_data  output  WIDTH  selected operand
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream accepts the beat
- sel_err  output  1  sticky out-of-range-select flag (present only with OPERAND_MUX_SEL_CHECK_EN)

## Operation
- Mux: sel < N_IN selects input sel. sel >= N_IN (non-power-of-2 N_IN) yields all-zero data.
- Storage: main register (drives out_data/out_valid) plus skid register. Each has a valid bit.
- in_ready = !skid_valid. It comes straight from a flop and has no combinational path from out_ready.
- Accept occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready.
- State transitions (M = main valid, S = skid valid):
  - EMPTY (M=0,S=0): accept → ONE.
  - ONE (M=1,S=0): accept & pop → ONE with the new data in main. Accept & !pop → FULL, with the new data in skid. Pop & !accept → EMPTY.
  - FULL (M=1,S=1): in_ready=0. Pop → ONE, skid moves into main.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- Flush dominates all other inputs in its cycle. Both valids clear and both data registers zero. An input presented in the same cycle is not accepted. Any pop in the same cycle still counts as taken by downstream.
- Reset mid-operation discards all beats immediately (asynchronous).

## Timing
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 beat/cycle with out_ready held high.
- out_data and out_valid are fully registered.
- Reset values: out_valid=0, out_data=0, skid cleared, in_ready=1, sel_err=0.
- out_data is stable while out_valid=1 and out_ready=0.
- A beat accepted while in FULL is impossible by construction (in_ready=0).

## Configuration
- OPERAND_MUX_SEL_CHECK_EN defined:
  - Adds the sel_err port.
  - sel_err sets on the cycle after an accepted beat has sel >= N_IN.
  - It is sticky and clears only on reset or flush.
  - Data for the offending beat is zero.
- Not defined: no sel_err port and no error register. Out-of-range select still yields zero data.

## Structure
- Shared package operand_mux_pkg:
  - OPMUX_DEF_WIDTH=32
  - OPMUX_DEF_N_IN=4
  - OPMUX_MAX_N_IN=16
  - the localparam function for SEL_W
- One natural sub-module, skid_buffer_2: a WIDTH-parametrised two-entry valid/ready buffer with flush.
- The top level holds the mux, the error logic and the skid_buffer_2 instance.

## Test plan
- Reset, then streaming: N_IN=4, inputs 0x11/0x22/0x33/0x44, sel=2, in_valid=1, out_ready=1 → out_valid rises 1 cycle after the first accept. out_data=0x33 every cycle after that, and in_ready stays 1.
- Backpressure: ONE state, out_ready=0, two further beats A then B offered → A is accepted into skid and in_ready drops. B is held off until the first pop. Output order is main, then A, then B.
- Flush while FULL, with in_valid=1 → the next cycle has out_valid=0, out_data=0 and in_ready=1, and the offered beat is not accepted.
- Out-of-range select: N_IN=3, sel=3 → out_data=0. With the macro, sel_err=1 the next cycle, holding until flush.
- Async reset in FULL: rst_n low mid-cycle → out_valid=0 and in_ready=1 immediately, with no clock edge required.
- Random valid/ready: 10k cycles against a scoreboard → no loss, no duplication, no reordering.
